seq_mul_ctrl: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 19 +
 rtl/seq_mul_ctrl.sv | 98 +++++++++
 tb/tb_seq_mul_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the repeated-addition multiplier controller.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SEQ_MUL_WIDTH_DEF = 3;

    // A legal operand needs at most 2**width-1 add cycles plus one zero-detect
    // cycle, so any count beyond that means b_zero never arrived.
    function automatic int unsigned timeout_limit(input int unsigned width);
        return (32'd1 << width) + 32'd1;
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// FSM sequencing operand load, repeated add / B decrement and a done pulse.
// Optional ADD-state watchdog: define SEQ_MUL_TIMEOUT_EN to build it.
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic b_zero,
    output logic load_a,
    output logic load_b,
    output logic dec_b,
    output logic acc_clr,
    output logic acc_en,
    output logic busy,
    output logic done,
    output logic err
);

    state_t r_state;
    logic   w_timeout;
    logic   w_add;

`ifdef SEQ_MUL_TIMEOUT_EN
    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(timeout_limit(WIDTH));

    logic [WIDTH:0] r_cnt;
    logic           r_err;

    assign w_timeout = (r_state == ADD) && !b_zero && (r_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == LOAD)
                r_cnt <= '0;
            else if (r_state == ADD)
                r_cnt <= r_cnt + 1'b1;
            // Set on the exit cycle so it lines up with the DONE pulse.
            r_err <= w_timeout;
        end
    end

    assign err = r_err;
`else
    if (WIDTH < 1) begin : g_width_chk
        $error("seq_mul_ctrl: WIDTH must be at least 1");
    end

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) r_state <= LOAD;
                LOAD:    r_state <= ADD;
                ADD:     if (b_zero || w_timeout) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // The add/decrement strobe must drop in the zero-detect cycle, so it
    // follows b_zero combinationally rather than being registered.
    assign w_add = (r_state == ADD) && !b_zero && !w_timeout;

    always_comb begin
        load_a  = 1'b0;
        load_b  = 1'b0;
        acc_clr = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            LOAD: begin
                load_a  = 1'b1;
                load_b  = 1'b1;
                acc_clr = 1'b1;
                busy    = 1'b1;
            end
            ADD:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign acc_en = w_add;
    assign dec_b  = w_add;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Scoreboard bench for seq_mul_ctrl driving a behavioural multiplier datapath.
module tb_seq_mul_ctrl;

    localparam int W = 3;

    typedef struct {
        logic [31:0] prod;
        logic [31:0] err;
        logic [31:0] done_cyc;
        logic [31:0] adds;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, b_zero;
    logic load_a, load_b, dec_b, acc_clr, acc_en, busy, done, err;

    logic [W-1:0]   a_in = '0, b_in = '0;
    logic [W-1:0]   m_a = '0, m_b = '0;
    logic [2*W-1:0] m_acc = '0;
    logic           force_nz = 1'b0;

    int   cyc = 0;
    int   n_cmp = 0, n_mis = 0;
    int   n_adds = 0, n_loads = 0;
    logic mon_en = 1'b0;
    exp_t sb[$];

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .b_zero(b_zero),
        .load_a(load_a), .load_b(load_b), .dec_b(dec_b), .acc_clr(acc_clr),
        .acc_en(acc_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: not reset, so an aborted product survives a reset.
    always @(posedge clk) begin
        if (load_a) m_a <= a_in;
        if (load_b) m_b <= b_in;
        else if (dec_b) m_b <= m_b - 1'b1;
        if (acc_clr) m_acc <= '0;
        else if (acc_en) m_acc <= m_acc + {{W{1'b0}}, m_a};
    end

    assign b_zero = force_nz ? 1'b0 : (m_b == '0);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("exclusive_ctrl", 32'((load_b && dec_b) || (acc_clr && acc_en) || (err && !done)), 0);
            if (load_a) begin
                n_loads++;
                n_adds = 0;
            end
            if (acc_en) n_adds++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", 32'(m_acc), e.prod);
                    check("err", 32'(err), e.err);
                    check("done_cycle", cyc, e.done_cyc);
                    check("add_count", n_adds, e.adds);
                    check("busy_in_done", 32'(busy), 0);
                end
            end
        end
    end

    task automatic issue(input int a, input int b);
        exp_t e;
        a_in  = W'(a);
        b_in  = W'(b);
        start = 1'b1;
        e.prod = 32'(a * b); e.err = 0; e.done_cyc = 32'(cyc + 3 + b); e.adds = 32'(b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(sb.size()), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, l0;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({load_a, load_b, dec_b, acc_clr, acc_en, busy, done, err}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'({load_a, load_b, dec_b, acc_clr, acc_en, busy, done, err}), 0);
        mon_en = 1'b1;

        // 5 x 3, then the product must hold through idle cycles.
        issue(5, 3);
        check("load_cycle", 32'({load_a, load_b, acc_clr, busy}), 32'hF);
        drain();
        for (int i = 0; i < 5; i++) begin
            check("held_product", 32'(m_acc), 15);
            check("idle_busy", 32'(busy), 0);
            @(negedge clk);
        end

        issue(4, 0);
        drain();
        issue(7, 7);
        drain();

        // start held high: one op, then a second starting in the IDLE after DONE.
        l0 = n_loads;
        t  = cyc;
        a_in = 3'd3; b_in = 3'd2; start = 1'b1;
        sb.push_back('{prod: 6, err: 0, done_cyc: 32'(t + 5), adds: 2});
        sb.push_back('{prod: 6, err: 0, done_cyc: 32'(t + 11), adds: 2});
        while (cyc < t + 7) @(negedge clk);
        start = 1'b0;
        drain();
        check("held_start_loads", 32'(n_loads - l0), 2);

        // Reset during the 2nd ADD cycle abandons the op with no done pulse.
        t = cyc;
        a_in = 3'd5; b_in = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 3) @(negedge clk);
        check("second_add_cycle", 32'(acc_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_outputs", 32'({load_a, load_b, dec_b, acc_clr, acc_en, busy, done, err}), 0);
        repeat (6) @(negedge clk);
        issue(6, 2);
        drain();

`ifdef SEQ_MUL_TIMEOUT_EN
        force_nz = 1'b1;
        t = cyc;
        a_in = 3'd1; b_in = 3'd3; start = 1'b1;
        sb.push_back('{prod: 9, err: 1, done_cyc: 32'(t + 12), adds: 9});
        @(negedge clk);
        start = 1'b0;
        drain();
        force_nz = 1'b0;
        check("timeout_back_idle", 32'({busy, done, err}), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
